img2col_window_gen: RTL and testbench
=====================================

# img2col_window_gen

Parametrised img2col window generator for the CNN accelerator. It accepts one K-pixel image column per handshake and keeps the newest K columns in a column shift register. For every stride position it emits the flattened K×K window to a processing unit (PU). A neighbour-PU preload lets a row start from K-1 overlap columns that an adjacent PU supplies, so those columns are not re-fetched. It replaces the fixed 5×5 PU control with configurable kernel size, stride, row width, row count and ready/valid backpressure.

## Interface
- DATA_W, 16, pixel width
- K, 5, kernel size (window is K×K), K ≥ 2
- MAX_W, 256, maximum columns per row
- MAX_ROWS, 256, maximum rows per frame
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- start  in  1  start frame; sampled only in IDLE
- cfg_width  in  $clog2(MAX_W+1)  streamed columns per row
- cfg_rows  in  $clog2(MAX_ROWS+1)  rows per frame; 0 is treated as 1
- cfg_stride  in  $clog2(K+1)  window stride 1..K; 0 is treated as 1; values above K clamp to K
- cfg_nb_en  in  1  each row starts with a neighbour preload
- in_col  in  K*DATA_W  one column; row r occupies bits [r*DATA_W +: DATA_W]
- in_valid / in_ready  in / out  1  column handshake
- nb_in  in  (K-1)*K*DATA_W  K-1 overlap columns; column c occupies bits [c*K*DATA_W +: K*DATA_W], c=0 is oldest
- nb_in_valid / nb_in_ready  in / out  1  preload handshake
- out_win  out  K*K*DATA_W  window; element (r,c) occupies bits [(r*K+c)*DATA_W +: DATA_W], c=0 is oldest column
- out_valid / out_ready  out / in  1  window handshake
- out_last  out  1  qualifies the last window of a row
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at frame end

## Operation
- **States.**
  - IDLE: on start, latch all cfg_* inputs. Go to PRELOAD if cfg_nb_en is set, otherwise go to STREAM.
  - PRELOAD: nb_in_ready=1 and in_ready=0. On nb_in_valid, load the K-1 newest register slots, set fill=K-1 and go to STREAM.
  - STREAM: accept columns.
  - DRAIN: wait until out_valid=0, then pulse done and return to IDLE.
- **Transfers.** A transfer occurs when valid&ready are both high in the same cycle.
- **Input ready.** in_ready = (state==STREAM) && (!out_valid || out_ready).
- **Column accept.**
  - Shift the register: the new column becomes the newest and the oldest drops out.
  - col_cnt++ and fill = min(fill+1, K).
- **Stride counter.**
  - skip is cleared at row start.
  - A window is produced when fill reaches K on this accept and (skip==0 or skip==S-1). After producing a window, skip clears to 0; otherwise skip++ once fill==K.
  - Result: the first window of a row comes when the register first fills, and each subsequent window comes every S columns.
- **Window output.** A produced window is registered into out_win. out_valid is set and held, with out_win stable, until out_ready.
- **out_last.** Set with a window when that window's column is the row's last column (col_cnt==cfg_width-1).
- **Row end.** When column cfg_width-1 is accepted:
  - clear fill, col_cnt and skip, and increment row_cnt;
  - if row_cnt reaches cfg_rows go to DRAIN, else go to PRELOAD (cfg_nb_en=1) or stay in STREAM.
  - No window spans two rows.
- **Window count per row.** With N = cfg_width + (cfg_nb_en ? K-1 : 0) effective columns:
  - N ≥ K gives floor((N-K)/S)+1 windows;
  - N < K gives zero windows; columns are still consumed and row/done accounting is unchanged.
- **Widths and ordering.** Pixel data is passed through, never arithmetically modified. All counters are unsigned, sized by MAX_W and MAX_ROWS.

## Timing
- **Reset.** nrst low forces all state and outputs to 0 immediately: state=IDLE, out_valid=0, out_last=0, in_ready=0, nb_in_ready=0, busy=0, done=0, out_win=0.
- **Reset mid-frame.** The frame is aborted; no partial window is output after release.
- **Latency.** 1 cycle from the accept of a completing column to out_valid=1.
- **Throughput.** With out_ready held at 1, one column is accepted per cycle.
- **Simultaneous events.** When out_ready and a completing in_valid arrive in the same cycle, the old window leaves and the new window loads with no bubble.
- **Backpressure.** When out_valid=1 and out_ready=0, in_ready=0 and nothing shifts.
- **Frame end.** done asserts the cycle after DRAIN sees out_valid=0, which is at least 1 cycle after the last window handshake.
- **start outside IDLE** is ignored.

## Test plan
- **Stride 1.** K=3, W=6, S=1, rows=1, cols = pixel values 1..6 (all rows equal) → 4 windows, first column sets {1,2,3},{2,3,4},{3,4,5},{4,5,6}; out_last on the 4th window only; done once.
- **Stride 2.** K=3, W=7, S=2 → 3 windows starting at columns 0,2,4; W=2 → 0 windows and done still pulses.
- **Backpressure.** Hold out_ready=0 for 5 cycles after the first window → out_win stable, in_ready=0, no columns lost; total 4 windows in order.
- **Neighbour preload.** K=3, nb_en=1, W=2, nb_in = columns {A,B} → first window {A,B,c0} 1 cycle after c0 is accepted; 2 windows per row; 2 rows → 2 preload handshakes.
- **Row boundary.** rows=2, W=4, K=3 → 2 windows per row, and no window mixes columns from row 0 and row 1.
- **Reset mid-row.** Deassert nrst after the 2nd window → all outputs 0 and state IDLE; after release, a new start reproduces the full expected sequence.

Source files
------------

// File: rtl/img2col_window_gen.sv
// img2col window generator: shifts K-pixel columns through a history register and
// emits the flattened K x K window every stride position, with optional neighbour preload.
module img2col_window_gen #(
    parameter int DATA_W   = 16,
    parameter int K        = 5,
    parameter int MAX_W    = 256,
    parameter int MAX_ROWS = 256
) (
    input  logic                              clk,
    input  logic                              nrst,
    input  logic                              start,
    input  logic [$clog2(MAX_W+1)-1:0]        cfg_width,
    input  logic [$clog2(MAX_ROWS+1)-1:0]     cfg_rows,
    input  logic [$clog2(K+1)-1:0]            cfg_stride,
    input  logic                              cfg_nb_en,
    input  logic [K*DATA_W-1:0]               in_col,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [(K-1)*K*DATA_W-1:0]         nb_in,
    input  logic                              nb_in_valid,
    output logic                              nb_in_ready,
    output logic [K*K*DATA_W-1:0]             out_win,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_last,
    output logic                              busy,
    output logic                              done
);

    localparam int WW    = $clog2(MAX_W+1);
    localparam int RW    = $clog2(MAX_ROWS+1);
    localparam int SW    = $clog2(K+1);
    localparam int FW    = $clog2(K+1);
    localparam int COL_W = K*DATA_W;

    localparam logic [FW-1:0] FILL_FULL = FW'(K);
    localparam logic [FW-1:0] FILL_PRE  = FW'(K-1);

    typedef enum logic [1:0] {IDLE, PRELOAD, STREAM, DRAIN} state_t;

    state_t state, state_next;

    logic [WW-1:0] width_q, col_cnt;
    logic [RW-1:0] rows_q, row_cnt;
    logic [SW-1:0] stride_q, skip;
    logic [FW-1:0] fill;
    logic          nb_en_q;

    // Only the K-1 older columns are stored; the incoming column completes the window.
    logic [COL_W-1:0]        hist [K-1];
    logic [K*K*DATA_W-1:0]   win_next;

    logic col_acc, nb_acc, out_acc, last_col, row_final, produce;

    assign col_acc   = in_valid && in_ready;
    assign nb_acc    = nb_in_valid && nb_in_ready;
    assign out_acc   = out_valid && out_ready;
    assign last_col  = (col_cnt == width_q - WW'(1));
    assign row_final = ((row_cnt + RW'(1)) == rows_q);
    // First window when the register first fills, later ones every stride columns.
    assign produce   = col_acc && ((fill == FILL_PRE) ||
                                   ((fill == FILL_FULL) && (skip == stride_q - SW'(1))));

    always_comb begin
        // NOTE: default every always_comb output first so no path infers a latch.
        win_next = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K-1; c++)
                win_next[(r*K+c)*DATA_W +: DATA_W] = hist[c][r*DATA_W +: DATA_W];
            win_next[(r*K+K-1)*DATA_W +: DATA_W] = in_col[r*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = cfg_nb_en ? PRELOAD : STREAM;
            PRELOAD: if (nb_acc) state_next = STREAM;
            STREAM:  if (col_acc && last_col)
                         state_next = row_final ? DRAIN : (nb_en_q ? PRELOAD : STREAM);
            DRAIN:   if (!out_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready    = (state == STREAM) && (!out_valid || out_ready);
        nb_in_ready = (state == PRELOAD);
        busy        = (state != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            width_q   <= '0;
            rows_q    <= '0;
            stride_q  <= '0;
            nb_en_q   <= 1'b0;
            col_cnt   <= '0;
            row_cnt   <= '0;
            skip      <= '0;
            fill      <= '0;
            out_win   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            // NOTE: the column history is reset as well so an aborted frame leaves no stale pixels.
            for (int i = 0; i < K-1; i++) hist[i] <= '0;
        end else begin
            done <= (state == DRAIN) && !out_valid;

            if (state == IDLE && start) begin
                width_q  <= (cfg_width == '0) ? WW'(1) : cfg_width;
                rows_q   <= (cfg_rows == '0) ? RW'(1) : cfg_rows;
                stride_q <= (cfg_stride == '0) ? SW'(1) :
                            (cfg_stride > SW'(K)) ? SW'(K) : cfg_stride;
                nb_en_q  <= cfg_nb_en;
                col_cnt  <= '0;
                row_cnt  <= '0;
                skip     <= '0;
                fill     <= '0;
            end

            if (nb_acc) begin
                for (int c = 0; c < K-1; c++) hist[c] <= nb_in[c*COL_W +: COL_W];
                fill <= FILL_PRE;
                skip <= '0;
            end

            if (col_acc) begin
                for (int i = 0; i < K-2; i++) hist[i] <= hist[i+1];
                hist[K-2] <= in_col;
                if (last_col) begin
                    fill    <= '0;
                    col_cnt <= '0;
                    skip    <= '0;
                    row_cnt <= row_cnt + RW'(1);
                end else begin
                    col_cnt <= col_cnt + WW'(1);
                    fill    <= (fill == FILL_FULL) ? FILL_FULL : fill + FW'(1);
                    if (produce)
                        skip <= '0;
                    else if (fill >= FILL_PRE)
                        skip <= skip + SW'(1);
                end
            end

            if (produce) begin
                out_win   <= win_next;
                out_valid <= 1'b1;
                out_last  <= last_col;
            end else if (out_acc) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_img2col_window_gen.sv
// Directed self-checking bench for img2col_window_gen with K=3, 8-bit pixels.
// Pixel (row r, column value v) is v + 64*r so row ordering errors are visible.
module tb_img2col_window_gen;

    localparam int DW       = 8;
    localparam int K        = 3;
    localparam int MAX_W    = 16;
    localparam int MAX_ROWS = 4;
    localparam int COL_W    = K*DW;
    localparam int WIN_W    = K*K*DW;

    logic                          clk = 1'b0;
    logic                          nrst = 1'b0;
    logic                          start = 1'b0;
    logic [$clog2(MAX_W+1)-1:0]    cfg_width = '0;
    logic [$clog2(MAX_ROWS+1)-1:0] cfg_rows = '0;
    logic [$clog2(K+1)-1:0]        cfg_stride = '0;
    logic                          cfg_nb_en = 1'b0;
    logic [COL_W-1:0]              in_col = '0;
    logic                          in_valid = 1'b0;
    logic                          in_ready;
    logic [(K-1)*COL_W-1:0]        nb_in = '0;
    logic                          nb_in_valid = 1'b0;
    logic                          nb_in_ready;
    logic [WIN_W-1:0]              out_win;
    logic                          out_valid;
    logic                          out_ready = 1'b1;
    logic                          out_last;
    logic                          busy;
    logic                          done;

    img2col_window_gen #(.DATA_W(DW), .K(K), .MAX_W(MAX_W), .MAX_ROWS(MAX_ROWS)) dut (
        .clk(clk), .nrst(nrst), .start(start),
        .cfg_width(cfg_width), .cfg_rows(cfg_rows), .cfg_stride(cfg_stride), .cfg_nb_en(cfg_nb_en),
        .in_col(in_col), .in_valid(in_valid), .in_ready(in_ready),
        .nb_in(nb_in), .nb_in_valid(nb_in_valid), .nb_in_ready(nb_in_ready),
        .out_win(out_win), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct { logic [WIN_W-1:0] win; logic last; } win_t;
    win_t got_q[$];
    win_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   done_cnt = 0;
    int   nb_cnt = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            win_t w;
            w.win  = out_win;
            w.last = out_last;
            got_q.push_back(w);
        end
        if (done) done_cnt++;
        if (nb_in_valid && nb_in_ready) nb_cnt++;
    end

    function automatic logic [COL_W-1:0] mk_col(input int v);
        logic [COL_W-1:0] res;
        for (int r = 0; r < K; r++) res[r*DW +: DW] = DW'(v + 64*r);
        return res;
    endfunction

    function automatic logic [WIN_W-1:0] mk_win(input int a, input int b, input int c);
        logic [WIN_W-1:0] res;
        int v[3];
        v[0] = a; v[1] = b; v[2] = c;
        for (int r = 0; r < K; r++)
            for (int cc = 0; cc < K; cc++)
                res[(r*K+cc)*DW +: DW] = DW'(v[cc] + 64*r);
        return res;
    endfunction

    task automatic exp_add(input int a, input int b, input int c, input logic last);
        win_t w;
        w.win  = mk_win(a, b, c);
        w.last = last;
        exp_q.push_back(w);
    endtask

    task automatic push_col(input int v);
        bit ok = 0;
        in_col   = mk_col(v);
        in_valid = 1'b1;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                ok = 1;
            end
        end
        in_valid = 1'b0;
        if (!ok) check("in_timeout", 0, 1);
    endtask

    task automatic push_nb(input int a, input int b);
        bit ok = 0;
        nb_in       = {mk_col(b), mk_col(a)};
        nb_in_valid = 1'b1;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (nb_in_ready) begin
                @(posedge clk);
                #1;
                ok = 1;
            end
        end
        nb_in_valid = 1'b0;
        if (!ok) check("nb_timeout", 0, 1);
    endtask

    task automatic start_frame(input int w, input int rows, input int stride, input logic nb);
        @(posedge clk);
        #1;
        cfg_width  = 5'(w);
        cfg_rows   = 3'(rows);
        cfg_stride = 2'(stride);
        cfg_nb_en  = nb;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic stream_frame(input int w, input int rows, input int base);
        for (int r = 0; r < rows; r++)
            for (int i = 0; i < w; i++) push_col(base + r*w + i);
    endtask

    task automatic compare_frame(input string tag);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_win%0d", tag, i), got_q[i].win, exp_q[i].win);
            check($sformatf("%s_last%0d", tag, i), got_q[i].last, exp_q[i].last);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic finish_frame(input string tag, input int d0);
        bit seen = 0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge clk);
            if (done_cnt != d0) seen = 1;
        end
        if (!seen) check({tag, "_done_timeout"}, 0, 1);
        repeat (3) @(negedge clk);
        check({tag, "_done_once"}, done_cnt - d0, 1);
        check({tag, "_idle"}, busy, 0);
        compare_frame(tag);
    endtask

    initial begin
        int d0;
        int n0;
        logic [WIN_W-1:0] held;
        bit seen;

        // Reset state
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_nb_ready", nb_in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out_win", out_win, 0);
        @(negedge clk);
        nrst = 1'b1;

        // Stride 1, K=3, W=6
        d0 = done_cnt;
        start_frame(6, 1, 1, 1'b0);
        check("s1_busy", busy, 1);
        stream_frame(6, 1, 1);
        exp_add(1, 2, 3, 0); exp_add(2, 3, 4, 0); exp_add(3, 4, 5, 0); exp_add(4, 5, 6, 1);
        finish_frame("s1", d0);

        // Stride 2, W=7: windows at columns 0,2,4
        d0 = done_cnt;
        start_frame(7, 1, 2, 1'b0);
        stream_frame(7, 1, 1);
        exp_add(1, 2, 3, 0); exp_add(3, 4, 5, 0); exp_add(5, 6, 7, 1);
        finish_frame("s2", d0);

        // Stride 2, W=2: no windows, done still pulses
        d0 = done_cnt;
        start_frame(2, 1, 2, 1'b0);
        stream_frame(2, 1, 1);
        finish_frame("s2_short", d0);

        // Stride 3 (= K), W=6: windows at columns 0 and 3
        d0 = done_cnt;
        start_frame(6, 1, 3, 1'b0);
        stream_frame(6, 1, 1);
        exp_add(1, 2, 3, 0); exp_add(4, 5, 6, 1);
        finish_frame("s3", d0);

        // Stride 0 and rows 0 both behave as 1
        d0 = done_cnt;
        start_frame(4, 0, 0, 1'b0);
        stream_frame(4, 1, 1);
        exp_add(1, 2, 3, 0); exp_add(2, 3, 4, 1);
        finish_frame("zero_cfg", d0);

        // Backpressure: out_ready low for 5 cycles after the first window
        d0 = done_cnt;
        out_ready = 1'b0;
        start_frame(6, 1, 1, 1'b0);
        fork
            stream_frame(6, 1, 1);
            begin
                seen = 0;
                for (int t = 0; t < 50 && !seen; t++) begin
                    @(negedge clk);
                    if (out_valid) seen = 1;
                end
                if (!seen) check("bp_valid_timeout", 0, 1);
                held = out_win;
                check("bp_first_win", held, mk_win(1, 2, 3));
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    check($sformatf("bp_stable%0d", c), out_win, held);
                    check($sformatf("bp_in_ready%0d", c), in_ready, 0);
                    check($sformatf("bp_valid%0d", c), out_valid, 1);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        exp_add(1, 2, 3, 0); exp_add(2, 3, 4, 0); exp_add(3, 4, 5, 0); exp_add(4, 5, 6, 1);
        finish_frame("bp", d0);

        // Neighbour preload: K=3, W=2, 2 rows
        d0 = done_cnt;
        n0 = nb_cnt;
        start_frame(2, 2, 1, 1'b1);
        for (int r = 0; r < 2; r++) begin
            push_nb(20 + 2*r, 21 + 2*r);
            push_col(1 + 2*r);
            check($sformatf("nb_latency%0d", r), out_valid, 1);
            check($sformatf("nb_first%0d", r), out_win, mk_win(20 + 2*r, 21 + 2*r, 1 + 2*r));
            push_col(2 + 2*r);
        end
        exp_add(20, 21, 1, 0); exp_add(21, 1, 2, 1);
        exp_add(22, 23, 3, 0); exp_add(23, 3, 4, 1);
        finish_frame("nb", d0);
        check("nb_preloads", nb_cnt - n0, 2);

        // Row boundary: 2 rows of W=4, no window spans rows
        d0 = done_cnt;
        start_frame(4, 2, 1, 1'b0);
        stream_frame(4, 2, 1);
        exp_add(1, 2, 3, 0); exp_add(2, 3, 4, 1);
        exp_add(5, 6, 7, 0); exp_add(6, 7, 8, 1);
        finish_frame("rows", d0);

        // Reset mid-row after the 2nd window
        start_frame(6, 1, 1, 1'b0);
        for (int v = 1; v <= 4; v++) push_col(v);
        @(negedge clk);
        #2;
        nrst = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_last", out_last, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out_win", out_win, 0);
        got_q.delete();
        @(negedge clk);
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_no_win", got_q.size(), 0);
        check("post_rst_idle", busy, 0);
        d0 = done_cnt;
        start_frame(6, 1, 1, 1'b0);
        stream_frame(6, 1, 1);
        exp_add(1, 2, 3, 0); exp_add(2, 3, 4, 0); exp_add(3, 4, 5, 0); exp_add(4, 5, 6, 1);
        finish_frame("after_rst", d0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
